// File: rtl/bsg_crossbar_o_by_i_rr.sv
// Registered i_els_p x o_els_p crossbar: per-output round-robin arbitration into a one-entry valid/yumi slot.
// Define BSG_XBAR_FIXED_PRIO_EN to replace round-robin with fixed priority (lowest input index wins).
module bsg_crossbar_o_by_i_rr #(
  parameter int i_els_p = 4,
  parameter int o_els_p = 4,
  parameter int width_p = 32,
  localparam int dest_w_lp = (o_els_p > 1) ? $clog2(o_els_p) : 1,
  localparam int src_w_lp  = (i_els_p > 1) ? $clog2(i_els_p) : 1
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic [i_els_p-1:0]            v_i,
  input  logic [i_els_p*width_p-1:0]    data_i,
  input  logic [i_els_p*dest_w_lp-1:0]  dest_i,
  output logic [i_els_p-1:0]            ready_o,
  output logic [o_els_p-1:0]            v_o,
  output logic [o_els_p*width_p-1:0]    data_o,
  output logic [o_els_p*src_w_lp-1:0]   src_o,
  input  logic [o_els_p-1:0]            yumi_i
);

  logic [i_els_p-1:0][width_p-1:0]   in_data;
  logic [i_els_p-1:0][dest_w_lp-1:0] in_dest;
  logic [i_els_p-1:0]                dest_hit;
  logic [o_els_p-1:0][i_els_p-1:0]   req;
  logic [o_els_p-1:0][i_els_p-1:0]   grant;
  logic [o_els_p-1:0]                can_load;
  logic [o_els_p-1:0][width_p-1:0]   mux_data;
  logic [o_els_p-1:0][src_w_lp-1:0]  win;
  logic [o_els_p-1:0]                v_r;
  logic [o_els_p-1:0][width_p-1:0]   data_r;
  logic [o_els_p-1:0][src_w_lp-1:0]  src_r;

  assign in_data = data_i;
  assign in_dest = dest_i;

  always_comb begin
    req      = '0;
    dest_hit = '0;
    for (int o = 0; o < o_els_p; o++) begin
      for (int i = 0; i < i_els_p; i++) begin
        if (in_dest[i] == dest_w_lp'(o)) begin
          dest_hit[i] = 1'b1;
          req[o][i]   = v_i[i];
        end
      end
    end
  end

  // Gating with reset keeps ready_o low while the block is held in reset.
  assign can_load = (~v_r | yumi_i) & {o_els_p{reset_n_i}};

`ifdef BSG_XBAR_FIXED_PRIO_EN
  always_comb begin
    logic found;
    found = 1'b0;
    grant = '0;
    for (int o = 0; o < o_els_p; o++) begin
      found = 1'b0;
      for (int i = 0; i < i_els_p; i++) begin
        if (!found && can_load[o] && req[o][i]) begin
          grant[o][i] = 1'b1;
          found       = 1'b1;
        end
      end
    end
  end
`else
  logic [o_els_p-1:0][src_w_lp-1:0] ptr_r;

  // Search begins one past the last winner and wraps, so the last winner is lowest priority.
  always_comb begin
    logic found;
    int   idx;
    found = 1'b0;
    idx   = 0;
    grant = '0;
    for (int o = 0; o < o_els_p; o++) begin
      found = 1'b0;
      for (int k = 1; k <= i_els_p; k++) begin
        idx = int'(ptr_r[o]) + k;
        if (idx >= i_els_p) idx = idx - i_els_p;
        if (!found && can_load[o] && req[o][idx]) begin
          grant[o][idx] = 1'b1;
          found         = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int o = 0; o < o_els_p; o++) ptr_r[o] <= src_w_lp'(i_els_p - 1);
    end else begin
      for (int o = 0; o < o_els_p; o++) begin
        if (|grant[o]) ptr_r[o] <= win[o];
      end
    end
  end
`endif

  always_comb begin
    mux_data = '0;
    win      = '0;
    for (int o = 0; o < o_els_p; o++) begin
      for (int i = 0; i < i_els_p; i++) begin
        mux_data[o] = mux_data[o] | ({width_p{grant[o][i]}} & in_data[i]);
        win[o]      = win[o] | ({src_w_lp{grant[o][i]}} & src_w_lp'(i));
      end
    end
  end

  always_comb begin
    ready_o = '0;
    for (int o = 0; o < o_els_p; o++) ready_o = ready_o | grant[o];
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_r    <= '0;
      data_r <= '0;
      src_r  <= '0;
    end else begin
      for (int o = 0; o < o_els_p; o++) begin
        if (|grant[o]) begin
          v_r[o]    <= 1'b1;
          data_r[o] <= mux_data[o];
          src_r[o]  <= win[o];
        end else if (yumi_i[o]) begin
          v_r[o] <= 1'b0;
        end
      end
    end
  end

  assign v_o    = v_r;
  assign data_o = data_r;
  assign src_o  = src_r;

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (reset_n_i) begin
      for (int o = 0; o < o_els_p; o++) begin
        assert (!(yumi_i[o] && !v_r[o])) else $error("yumi_i[%0d] asserted with v_o low", o);
        assert ($onehot0(grant[o])) else $error("grant[%0d] not one-hot", o);
      end
      for (int i = 0; i < i_els_p; i++) begin
        assert (!(v_i[i] && !dest_hit[i])) else $error("dest_i[%0d] out of range", i);
      end
    end
  end
`endif

endmodule
